fixed_mac_arbiter: RTL and testbench

Round-robin scheduler that shares one `fixed_mac` instance between `N_REQ` requesters. Each requester presents a packet of paired A/B operands terminated by `last`. The arbiter grants one requester per packet, forwards its beats to the MAC, then waits for the MAC's accumulated result. It returns that result to the granted requester with an ID tag, overflow/underflow flags and a beat count. It sits between the stream sources and the `fixed_mac` A/B/out channels.

---
 rtl/fixed_mac_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_fixed_mac_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_arbiter.sv
// Round-robin arbiter sharing one fixed_mac between N_REQ packet requesters.
// Optional DRAIN watchdog enabled by defining FIXED_MAC_ARB_TIMEOUT_EN.
module fixed_mac_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned WA          = 12,
  parameter int unsigned WB          = 8,
  parameter int unsigned WOUT        = 45,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ*WA-1:0]    req_a_data,
  input  logic [N_REQ*WB-1:0]    req_b_data,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WA-1:0]          mac_a_data,
  output logic [WB-1:0]          mac_b_data,
  output logic                   mac_a_valid,
  output logic                   mac_b_valid,
  output logic                   mac_a_last,
  output logic                   mac_b_last,
  input  logic                   mac_a_ready,
  input  logic                   mac_b_ready,
  input  logic [WOUT-1:0]        mac_out_data,
  input  logic                   mac_out_valid,
  input  logic                   mac_overflow,
  input  logic                   mac_underflow,
  output logic                   mac_out_ready,
  output logic [WOUT-1:0]        resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic [CNT_W-1:0]       resp_beats,
  output logic                   resp_ovf,
  output logic                   resp_unf,
  output logic                   resp_error,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   busy
);

  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || TIMEOUT_CYC < 1) begin : g_param_err
    $error("fixed_mac_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StResp} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [ID_W-1:0]  r_grant;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_pick;
  logic             w_any;
  logic [CNT_W-1:0] r_beats;
  logic [WOUT-1:0]  r_resp_data;
  logic             r_ovf;
  logic             r_unf;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_mac_rdy;
  logic             w_beat;
  logic [ID_W-1:0]  w_ptr_next;

  // First requester at or after rr_ptr; iterate downwards so the smallest offset wins.
  always_comb begin
    w_pick = r_rr_ptr;
    w_any  = 1'b0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % int'(N_REQ)]) begin
        w_pick = ID_W'((int'(r_rr_ptr) + k) % int'(N_REQ));
        w_any  = 1'b1;
      end
    end
  end

  assign w_g_valid  = req_valid[r_grant];
  assign w_g_last   = req_last[r_grant];
  assign w_mac_rdy  = mac_a_ready & mac_b_ready;
  assign w_beat     = (r_state == StStream) & w_g_valid & w_mac_rdy;
  assign w_ptr_next = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + ID_W'(1);

`ifdef FIXED_MAC_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_expire;
  logic            r_err;

  assign w_wd_expire = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign resp_error  = r_err;

  // Counter sits at zero outside DRAIN, so it restarts on every DRAIN entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != StDrain) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_expire) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end
`else
  assign resp_error = 1'b0;
`endif

  always_comb begin
    w_state_d     = r_state;
    req_ready     = '0;
    mac_a_data    = '0;
    mac_b_data    = '0;
    mac_a_valid   = 1'b0;
    mac_b_valid   = 1'b0;
    mac_a_last    = 1'b0;
    mac_b_last    = 1'b0;
    mac_out_ready = 1'b0;
    resp_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) w_state_d = StStream;
      end
      StStream: begin
        mac_a_data         = req_a_data[r_grant*WA +: WA];
        mac_b_data         = req_b_data[r_grant*WB +: WB];
        mac_a_valid        = w_g_valid;
        mac_b_valid        = w_g_valid;
        mac_a_last         = w_g_last;
        mac_b_last         = w_g_last;
        req_ready[r_grant] = w_mac_rdy;
        if (w_beat && w_g_last) w_state_d = StDrain;
      end
      StDrain: begin
        mac_out_ready = 1'b1;
        if (mac_out_valid) begin
          w_state_d = StResp;
        end
`ifdef FIXED_MAC_ARB_TIMEOUT_EN
        else if (w_wd_expire) begin
          w_state_d = StResp;
        end
`endif
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beats     <= '0;
      r_resp_data <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
`ifdef FIXED_MAC_ARB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_any) r_grant <= w_pick;
        end
        StStream: begin
          if (w_beat && (r_beats != '1)) r_beats <= r_beats + CNT_W'(1);
        end
        StDrain: begin
          if (mac_out_valid) begin
            r_resp_data <= mac_out_data;
            r_ovf       <= mac_overflow;
            r_unf       <= mac_underflow;
`ifdef FIXED_MAC_ARB_TIMEOUT_EN
            r_err       <= 1'b0;
          end else if (w_wd_expire) begin
            r_resp_data <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_err       <= 1'b1;
`endif
          end
        end
        StResp: begin
          if (resp_ready) begin
            r_rr_ptr <= w_ptr_next;
            r_beats  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data  = r_resp_data;
  assign resp_id    = r_grant;
  assign resp_beats = r_beats;
  assign resp_ovf   = r_ovf;
  assign resp_unf   = r_unf;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_fixed_mac_arbiter.sv
// Directed bench for fixed_mac_arbiter: cycle-level reference model plus literal checks.
// Watchdog scenario runs only when FIXED_MAC_ARB_TIMEOUT_EN is defined.
module tb_fixed_mac_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int WA  = 12;
  localparam int WB  = 8;
  localparam int WO  = 45;
  localparam int CW  = 16;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*WA-1:0] req_a_data;
  logic [N*WB-1:0] req_b_data;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [WA-1:0]   mac_a_data;
  logic [WB-1:0]   mac_b_data;
  logic            mac_a_valid, mac_b_valid, mac_a_last, mac_b_last;
  logic            mac_a_ready, mac_b_ready;
  logic [WO-1:0]   mac_out_data;
  logic            mac_out_valid, mac_overflow, mac_underflow, mac_out_ready;
  logic [WO-1:0]   resp_data;
  logic [IDW-1:0]  resp_id;
  logic [CW-1:0]   resp_beats;
  logic            resp_ovf, resp_unf, resp_error, resp_valid, resp_ready, busy;

  logic [WA-1:0] tb_a [N];
  logic [WB-1:0] tb_b [N];
  logic          tb_valid [N];
  logic          tb_last [N];
  logic          tb_a_rdy, toggle_en, tgl;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a_data[i*WA +: WA] = tb_a[i];
      req_b_data[i*WB +: WB] = tb_b[i];
      req_valid[i]           = tb_valid[i];
      req_last[i]            = tb_last[i];
    end
  end

  always @(posedge clk) tgl <= ~tgl;
  assign mac_a_ready = tb_a_rdy & (~toggle_en | tgl);

  fixed_mac_arbiter #(
    .N_REQ(N), .ID_W(IDW), .WA(WA), .WB(WB), .WOUT(WO), .CNT_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a_data(req_a_data), .req_b_data(req_b_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready),
    .mac_a_data(mac_a_data), .mac_b_data(mac_b_data),
    .mac_a_valid(mac_a_valid), .mac_b_valid(mac_b_valid),
    .mac_a_last(mac_a_last), .mac_b_last(mac_b_last),
    .mac_a_ready(mac_a_ready), .mac_b_ready(mac_b_ready),
    .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid),
    .mac_overflow(mac_overflow), .mac_underflow(mac_underflow),
    .mac_out_ready(mac_out_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_beats(resp_beats),
    .resp_ovf(resp_ovf), .resp_unf(resp_unf), .resp_error(resp_error),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WA-1:0] pat_a(input int r, input int k);
    return WA'(r * 256 + k * 17 + 5);
  endfunction

  function automatic logic [WB-1:0] pat_b(input int r, input int k);
    return WB'(r * 32 + k * 3 + 1);
  endfunction

  // Reference model: who owns the MAC, whether the packet's last beat was seen,
  // whether a result is held, and the round-robin starting point.
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_beats = 0;
  int            m_wd    = 0;
  bit            m_done, m_have, m_ovf, m_unf, m_err;
  logic [WO-1:0] m_data;
  int            m_grants [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_wd = 0;
      m_done = 0; m_have = 0; m_ovf = 0; m_unf = 0; m_err = 0; m_data = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          break;
        end
      end
      if (m_owner >= 0) begin
        m_grants.push_back(m_owner);
        m_beats = 0; m_done = 0; m_have = 0; m_wd = 0;
      end
    end else if (!m_done) begin
      if (req_valid[m_owner] && mac_a_ready && mac_b_ready) begin
        if (m_beats < 65535) m_beats++;
        if (req_last[m_owner]) m_done = 1;
      end
    end else if (!m_have) begin
      if (mac_out_valid) begin
        m_have = 1; m_data = mac_out_data; m_ovf = mac_overflow; m_unf = mac_underflow; m_err = 0;
      end
`ifdef FIXED_MAC_ARB_TIMEOUT_EN
      else begin
        m_wd++;
        if (m_wd == TO) begin
          m_have = 1; m_data = '0; m_ovf = 0; m_unf = 0; m_err = 1;
        end
      end
`endif
    end else if (resp_ready) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_beats = 0;
    end
  end

  always @(negedge clk) begin
    bit         strm, drn, rsp;
    int         o;
    logic [N-1:0] er;
    o    = (m_owner < 0) ? 0 : m_owner;
    strm = (m_owner >= 0) && !m_done;
    drn  = (m_owner >= 0) && m_done && !m_have;
    rsp  = (m_owner >= 0) && m_have;
    er   = '0;
    if (strm && mac_a_ready && mac_b_ready) er[o] = 1'b1;
    chk("cyc_busy", 64'(busy), 64'(m_owner >= 0));
    chk("cyc_req_ready", 64'(req_ready), 64'(er));
    chk("cyc_a_valid", 64'(mac_a_valid), 64'(strm && tb_valid[o]));
    chk("cyc_b_valid", 64'(mac_b_valid), 64'(strm && tb_valid[o]));
    chk("cyc_a_last", 64'(mac_a_last), 64'(strm && tb_last[o]));
    chk("cyc_b_last", 64'(mac_b_last), 64'(strm && tb_last[o]));
    chk("cyc_out_ready", 64'(mac_out_ready), 64'(drn));
    chk("cyc_resp_valid", 64'(resp_valid), 64'(rsp));
    if (strm && tb_valid[o]) begin
      chk("cyc_a_data", 64'(mac_a_data), 64'(tb_a[o]));
      chk("cyc_b_data", 64'(mac_b_data), 64'(tb_b[o]));
    end
    if (rsp) begin
      chk("cyc_resp_data", 64'(resp_data), 64'(m_data));
      chk("cyc_resp_id", 64'(resp_id), 64'(m_owner));
      chk("cyc_resp_beats", 64'(resp_beats), 64'(m_beats));
      chk("cyc_resp_ovf", 64'(resp_ovf), 64'(m_ovf));
      chk("cyc_resp_unf", 64'(resp_unf), 64'(m_unf));
      chk("cyc_resp_err", 64'(resp_error), 64'(m_err));
    end
  end

  typedef struct {
    int            id;
    int            beats;
    logic [WO-1:0] data;
    bit            ovf;
    bit            unf;
  } resp_t;
  resp_t           rq [$];
  logic [WA-1:0]   fwd [$];

  always @(posedge clk) begin
    if (reset_n && resp_valid && resp_ready)
      rq.push_back('{int'(resp_id), int'(resp_beats), resp_data, resp_ovf, resp_unf});
  end

  always @(negedge clk) begin
    if (mac_a_valid && mac_a_ready && mac_b_ready) fwd.push_back(mac_a_data);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_pkt(input int r, input int n, input int bub, input int stop_after);
    for (int k = 0; k < n; k++) begin
      int  w;
      bit  acc;
      if (k == stop_after) break;
      if (bub[k]) begin
        tb_valid[r] = 1'b0;
        tick();
      end
      tb_a[r] = pat_a(r, k); tb_b[r] = pat_b(r, k);
      tb_last[r] = (k == n - 1); tb_valid[r] = 1'b1;
      w = 0; acc = 0;
      while (!acc && w < 400) begin
        @(negedge clk); acc = req_ready[r];
        tick(); w++;
      end
      if (!acc) begin
        chk("beat_timeout", 64'(0), 64'(1));
        break;
      end
    end
    tb_valid[r] = 1'b0; tb_last[r] = 1'b0;
  endtask

  // Acts as the MAC result side: waits for DRAIN, returns one result, then
  // holds resp_ready low for 'hold' response cycles before accepting.
  task automatic serve_one(input logic [WO-1:0] d, input bit ovf, input bit unf,
                           input int dly, input int hold);
    int n = 0;
    @(negedge clk);
    while (!mac_out_ready && n < 400) begin
      @(negedge clk); n++;
    end
    if (!mac_out_ready) begin
      chk("drain_timeout", 64'(0), 64'(1));
      return;
    end
    tick();
    repeat (dly) tick();
    mac_out_data = d; mac_overflow = ovf; mac_underflow = unf; mac_out_valid = 1'b1;
    @(negedge clk);
    chk("lat_resp_low", 64'(resp_valid), 64'(0));
    chk("lat_out_ready_hi", 64'(mac_out_ready), 64'(1));
    tick();
    mac_out_valid = 1'b0; mac_overflow = 1'b0; mac_underflow = 1'b0; mac_out_data = '0;
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("lat_resp_high", 64'(resp_valid), 64'(1));
    chk("lat_out_ready_lo", 64'(mac_out_ready), 64'(0));
    for (int k = 0; k < hold; k++) begin
      tick();
      if (k == hold - 1) resp_ready = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'(1));
      chk("hold_data", 64'(resp_data), 64'(d));
      chk("hold_ovf", 64'(resp_ovf), 64'(ovf));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tb_a[i] = '0; tb_b[i] = '0; tb_valid[i] = 1'b0; tb_last[i] = 1'b0;
    end
    tb_a_rdy = 1'b1; mac_b_ready = 1'b1; toggle_en = 1'b0; tgl = 1'b0;
    mac_out_data = '0; mac_out_valid = 1'b0; mac_overflow = 1'b0; mac_underflow = 1'b0;
    resp_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_a_valid", 64'(mac_a_valid), 64'(0));
    chk("rst_b_valid", 64'(mac_b_valid), 64'(0));
    chk("rst_a_last", 64'(mac_a_last), 64'(0));
    chk("rst_out_ready", 64'(mac_out_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_beats", 64'(resp_beats), 64'(0));
    chk("rst_resp_flags", 64'({resp_ovf, resp_unf, resp_error}), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Single requester, 3 beats, result 0x123
    rq.delete();
    fork
      drive_pkt(0, 3, 0, -1);
      serve_one(WO'(45'h123), 1'b0, 1'b0, 1, 0);
    join
    chk("t1_count", 64'(rq.size()), 64'(1));
    if (rq.size() == 1) begin
      chk("t1_id", 64'(rq[0].id), 64'(0));
      chk("t1_beats", 64'(rq[0].beats), 64'(3));
      chk("t1_data", 64'(rq[0].data), 64'(45'h123));
    end

    // Backpressure on A ready plus two bubbles in a 5-beat packet from requester 2
    rq.delete(); fwd.delete();
    toggle_en = 1'b1;
    fork
      drive_pkt(2, 5, 32'b01010, -1);
      serve_one(WO'(45'h0_5A5A_5A5A), 1'b0, 1'b0, 0, 0);
    join
    toggle_en = 1'b0;
    chk("t3_fwd_count", 64'(fwd.size()), 64'(5));
    for (int k = 0; k < 5 && k < fwd.size(); k++) chk("t3_fwd_data", 64'(fwd[k]), 64'(pat_a(2, k)));
    if (rq.size() == 1) begin
      chk("t3_id", 64'(rq[0].id), 64'(2));
      chk("t3_beats", 64'(rq[0].beats), 64'(5));
    end else chk("t3_count", 64'(rq.size()), 64'(1));

    // Mid-packet reset: requester 3 aborted after 2 of 4 beats
    rq.delete();
    drive_pkt(3, 4, 0, 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_req_ready", 64'(req_ready), 64'(0));
    chk("t5_a_valid", 64'(mac_a_valid), 64'(0));
    chk("t5_resp_beats", 64'(resp_beats), 64'(0));
    tick();
    reset_n = 1'b1;
    chk("t5_no_resp", 64'(rq.size()), 64'(0));
    fork
      drive_pkt(1, 1, 0, -1);
      drive_pkt(3, 1, 0, -1);
      begin
        serve_one(WO'(45'h11), 1'b0, 1'b0, 0, 0);
        serve_one(WO'(45'h33), 1'b0, 1'b0, 0, 0);
      end
    join
    if (rq.size() == 2) begin
      chk("t5_first_id", 64'(rq[0].id), 64'(1));
      chk("t5_second_id", 64'(rq[1].id), 64'(3));
    end else chk("t5_count", 64'(rq.size()), 64'(2));

    // All four request from reset, 2 beats each: grants 0,1,2,3
    rq.delete(); m_grants.delete();
    reset_n = 1'b0;
    fork
      drive_pkt(0, 2, 0, -1);
      drive_pkt(1, 2, 0, -1);
      drive_pkt(2, 2, 0, -1);
      drive_pkt(3, 2, 0, -1);
      begin
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) serve_one(WO'(45'h200 + i), 1'b0, 1'b0, 0, 0);
      end
    join
    chk("t2_grants", 64'(m_grants.size()), 64'(4));
    chk("t2_resps", 64'(rq.size()), 64'(4));
    for (int i = 0; i < 4 && i < m_grants.size(); i++) chk("t2_model_grant", 64'(m_grants[i]), 64'(i));
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      chk("t2_resp_id", 64'(rq[i].id), 64'(i));
      chk("t2_resp_data", 64'(rq[i].data), 64'(45'h200 + i));
    end

    // Overflow flag, 10-cycle response hold with a competing request, then single-beat packet
    rq.delete();
    fork
      drive_pkt(1, 2, 0, -1);
      begin
        tick(); tick(); tick();
        drive_pkt(3, 1, 0, -1);
      end
      begin
        serve_one(WO'(45'h1A_BCDE_F012), 1'b1, 1'b0, 2, 10);
        serve_one(WO'(45'h0ABC), 1'b0, 1'b1, 0, 0);
      end
    join
    if (rq.size() == 2) begin
      chk("t4_id0", 64'(rq[0].id), 64'(1));
      chk("t4_beats0", 64'(rq[0].beats), 64'(2));
      chk("t4_ovf0", 64'(rq[0].ovf), 64'(1));
      chk("t4_data0", 64'(rq[0].data), 64'(45'h1A_BCDE_F012));
      chk("t4_id1", 64'(rq[1].id), 64'(3));
      chk("t4_beats1", 64'(rq[1].beats), 64'(1));
      chk("t4_unf1", 64'(rq[1].unf), 64'(1));
    end else chk("t4_count", 64'(rq.size()), 64'(2));

`ifdef FIXED_MAC_ARB_TIMEOUT_EN
    // Watchdog: no MAC result, response with error 16 cycles after DRAIN entry
    begin
      int n;
      int cyc;
      drive_pkt(0, 1, 0, -1);
      n = 0;
      @(negedge clk);
      while (!mac_out_ready && n < 50) begin
        @(negedge clk); n++;
      end
      cyc = 0;
      while (!resp_valid && cyc < 100) begin
        @(negedge clk); cyc++;
      end
      chk("wd_latency", 64'(cyc), 64'(16));
      chk("wd_error", 64'(resp_error), 64'(1));
      chk("wd_data", 64'(resp_data), 64'(0));
      chk("wd_out_ready", 64'(mac_out_ready), 64'(0));
      tick();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
